// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, state/op-class encodings and per-state strobe decode for the datapath control unit
package cpu_ctrl_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_RST  = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_HALT = 4'd8
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU     = 3'd0,
      CLS_MULDIV  = 3'd1,
      CLS_NOP     = 3'd2,
      CLS_HALT    = 3'd3,
      CLS_ILLEGAL = 3'd4
   } op_class_t;

   // One bit per datapath strobe; ALU_op is carried separately.
   typedef struct packed {
      logic pc_out;
      logic zlow_out;
      logic zhigh_out;
      logic mdr_out;
      logic pc_in;
      logic mar_in;
      logic mdr_in;
      logic ir_in;
      logic y_in;
      logic zlow_in;
      logic zhigh_in;
      logic hi_in;
      logic lo_in;
      logic inc_pc;
      logic read;
      logic gra;
      logic grb;
      logic grc;
      logic r_in;
      logic r_out;
      logic run;
   } ctrl_t;

   // T5 is the only step whose strobes depend on the instruction class.
   function automatic ctrl_t decode_state(input state_t s, input op_class_t cls);
      ctrl_t c;
      c = '0;
      case (s)
         ST_T0: begin
            c.pc_out = 1'b1;
            c.mar_in = 1'b1;
            c.inc_pc = 1'b1;
            c.pc_in  = 1'b1;
         end
         ST_T1: begin
            c.read   = 1'b1;
            c.mdr_in = 1'b1;
         end
         ST_T2: begin
            c.mdr_out = 1'b1;
            c.ir_in   = 1'b1;
         end
         ST_T3: begin
            c.grb   = 1'b1;
            c.r_out = 1'b1;
            c.y_in  = 1'b1;
         end
         ST_T4: begin
            c.grc      = 1'b1;
            c.r_out    = 1'b1;
            c.zlow_in  = 1'b1;
            c.zhigh_in = 1'b1;
         end
         ST_T5: begin
            c.zlow_out = 1'b1;
            if (cls == CLS_MULDIV) begin
               c.lo_in = 1'b1;
            end else begin
               c.gra  = 1'b1;
               c.r_in = 1'b1;
            end
         end
         ST_T6: begin
            c.zhigh_out = 1'b1;
            c.hi_in     = 1'b1;
         end
         default: ;
      endcase
      c.run = (s != ST_RST) && (s != ST_HALT);
      return c;
   endfunction

endpackage

// File: rtl/op_class_decode.sv
// rtl/op_class_decode.sv - combinational opcode to execute-class decoder
module op_class_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 5
) (
   input  logic [OPCODE_W-1:0] opcode,
   output logic [2:0]          op_class
);

   // Map each opcode onto the execute sequence it needs; anything unlisted is illegal.
   always_comb begin
      op_class = CLS_ILLEGAL;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  op_class = CLS_ALU;
         OP_MUL, OP_DIV:                   op_class = CLS_MULDIV;
         OP_NOP:                           op_class = CLS_NOP;
         OP_HALT:                          op_class = CLS_HALT;
         default:                          op_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/datapath_control_unit.sv
// rtl/datapath_control_unit.sv - Moore FSM sequencing the DataPath; ILLEGAL_OP_TRAP_EN turns unlisted opcodes into a faulting halt
module datapath_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 5,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                Clock,
   input  logic                Clear,
   input  logic [31:0]         IR,
   input  logic                Mem_ready,
   input  logic                Stop,
   output logic                PCout,
   output logic                Zlowout,
   output logic                ZHighout,
   output logic                MDRout,
   output logic                PCin,
   output logic                MARin,
   output logic                MDRin,
   output logic                IRin,
   output logic                Yin,
   output logic                ZLowIn,
   output logic                ZHighIn,
   output logic                HIin,
   output logic                LOin,
   output logic                IncPC,
   output logic                Read,
   output logic                Gra,
   output logic                Grb,
   output logic                Grc,
   output logic                Rin,
   output logic                Rout,
   output logic [OPCODE_W-1:0] ALU_op,
   output logic                Run,
   output logic                Fault
);

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t    state, state_nxt, bnd_state;
   op_class_t class_q, class_nxt, dec_class;
   logic [2:0] dec_class_raw;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       fault_nxt;
   ctrl_t      ctrl_q;
   logic       unused_ir;

   // Register fields are consumed by the DataPath through Gra/Grb/Grc.
   assign unused_ir = ^IR[31-OPCODE_W:0];

   op_class_decode #(
      .OPCODE_W (OPCODE_W)
   ) u_op_class_decode (
      .opcode   (IR[31 -: OPCODE_W]),
      .op_class (dec_class_raw)
   );

   assign dec_class = op_class_t'(dec_class_raw);

   // Stop is only looked at on the edge that closes an instruction.
   assign bnd_state = Stop ? ST_HALT : ST_T0;

   // Next state, memory wait counter and sticky fault.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = '0;
      fault_nxt    = Fault;
      class_nxt    = class_q;
      case (state)
         ST_RST: state_nxt = ST_T0;
         ST_T0:  state_nxt = ST_T1;
         ST_T1: begin
            if (Mem_ready) begin
               state_nxt = ST_T2;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt = ST_HALT;
               fault_nxt = 1'b1;
            end else begin
               state_nxt    = ST_T1;
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         ST_T2: begin
            class_nxt = dec_class;
            case (dec_class)
               CLS_ALU, CLS_MULDIV: state_nxt = ST_T3;
               CLS_HALT:            state_nxt = ST_HALT;
               CLS_ILLEGAL: begin
`ifdef ILLEGAL_OP_TRAP_EN
                  state_nxt = ST_HALT;
                  fault_nxt = 1'b1;
`else
                  state_nxt = bnd_state;
`endif
               end
               default:             state_nxt = bnd_state;
            endcase
         end
         ST_T3:  state_nxt = ST_T4;
         ST_T4:  state_nxt = ST_T5;
         ST_T5:  state_nxt = (class_q == CLS_MULDIV) ? ST_T6 : bnd_state;
         ST_T6:  state_nxt = bnd_state;
         default: state_nxt = ST_HALT;
      endcase
   end

   // State plus strobes registered from the next state, so outputs depend on state alone.
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state    <= ST_RST;
         wait_cnt <= '0;
         Fault    <= 1'b0;
         class_q  <= CLS_NOP;
         ctrl_q   <= '0;
         ALU_op   <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         Fault    <= fault_nxt;
         class_q  <= class_nxt;
         ctrl_q   <= decode_state(state_nxt, class_nxt);
         ALU_op   <= (state_nxt == ST_T4) ? IR[31 -: OPCODE_W] : '0;
      end
   end

   assign PCout    = ctrl_q.pc_out;
   assign Zlowout  = ctrl_q.zlow_out;
   assign ZHighout = ctrl_q.zhigh_out;
   assign MDRout   = ctrl_q.mdr_out;
   assign PCin     = ctrl_q.pc_in;
   assign MARin    = ctrl_q.mar_in;
   assign MDRin    = ctrl_q.mdr_in;
   assign IRin     = ctrl_q.ir_in;
   assign Yin      = ctrl_q.y_in;
   assign ZLowIn   = ctrl_q.zlow_in;
   assign ZHighIn  = ctrl_q.zhigh_in;
   assign HIin     = ctrl_q.hi_in;
   assign LOin     = ctrl_q.lo_in;
   assign IncPC    = ctrl_q.inc_pc;
   assign Read     = ctrl_q.read;
   assign Gra      = ctrl_q.gra;
   assign Grb      = ctrl_q.grb;
   assign Grc      = ctrl_q.grc;
   assign Rin      = ctrl_q.r_in;
   assign Rout     = ctrl_q.r_out;
   assign Run      = ctrl_q.run;

endmodule

// File: tb/tb_datapath_control_unit.sv
// tb/tb_datapath_control_unit.sv - scoreboard bench for datapath_control_unit with an instruction-level reference model
module tb_datapath_control_unit;

   localparam int MEM_TIMEOUT = 16;

   localparam logic [26:0] M_PCOUT    = 27'd1 << 26;
   localparam logic [26:0] M_ZLOWOUT  = 27'd1 << 25;
   localparam logic [26:0] M_ZHIGHOUT = 27'd1 << 24;
   localparam logic [26:0] M_MDROUT   = 27'd1 << 23;
   localparam logic [26:0] M_PCIN     = 27'd1 << 22;
   localparam logic [26:0] M_MARIN    = 27'd1 << 21;
   localparam logic [26:0] M_MDRIN    = 27'd1 << 20;
   localparam logic [26:0] M_IRIN     = 27'd1 << 19;
   localparam logic [26:0] M_YIN      = 27'd1 << 18;
   localparam logic [26:0] M_ZLOWIN   = 27'd1 << 17;
   localparam logic [26:0] M_ZHIGHIN  = 27'd1 << 16;
   localparam logic [26:0] M_HIIN     = 27'd1 << 15;
   localparam logic [26:0] M_LOIN     = 27'd1 << 14;
   localparam logic [26:0] M_INCPC    = 27'd1 << 13;
   localparam logic [26:0] M_READ     = 27'd1 << 12;
   localparam logic [26:0] M_GRA      = 27'd1 << 11;
   localparam logic [26:0] M_GRB      = 27'd1 << 10;
   localparam logic [26:0] M_GRC      = 27'd1 << 9;
   localparam logic [26:0] M_RIN      = 27'd1 << 8;
   localparam logic [26:0] M_ROUT     = 27'd1 << 7;
   localparam logic [26:0] M_RUN      = 27'd1 << 6;
   localparam logic [26:0] M_FAULT    = 27'd1 << 5;

   localparam logic [26:0] W_T0  = M_PCOUT | M_MARIN | M_INCPC | M_PCIN | M_RUN;
   localparam logic [26:0] W_T1  = M_READ | M_MDRIN | M_RUN;
   localparam logic [26:0] W_T2  = M_MDROUT | M_IRIN | M_RUN;
   localparam logic [26:0] W_T3  = M_GRB | M_ROUT | M_YIN | M_RUN;
   localparam logic [26:0] W_T4  = M_GRC | M_ROUT | M_ZLOWIN | M_ZHIGHIN | M_RUN;
   localparam logic [26:0] W_T5A = M_ZLOWOUT | M_GRA | M_RIN | M_RUN;
   localparam logic [26:0] W_T5M = M_ZLOWOUT | M_LOIN | M_RUN;
   localparam logic [26:0] W_T6  = M_ZHIGHOUT | M_HIIN | M_RUN;

   localparam int K_ALU = 0, K_MULDIV = 1, K_NOP = 2, K_HALT = 3, K_ILL = 4;

   logic        Clock = 1'b0;
   logic        Clear = 1'b1;
   logic [31:0] IR = '0;
   logic        Mem_ready = 1'b0;
   logic        Stop = 1'b0;
   logic        PCout, Zlowout, ZHighout, MDRout, PCin, MARin, MDRin, IRin, Yin;
   logic        ZLowIn, ZHighIn, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout;
   logic [4:0]  ALU_op;
   logic        Run, Fault;

   always #5 Clock = ~Clock;

   datapath_control_unit #(.OPCODE_W(5), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
      .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
      .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
      .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .ALU_op(ALU_op), .Run(Run), .Fault(Fault)
   );

   logic [26:0] got;
   assign got = {PCout, Zlowout, ZHighout, MDRout, PCin, MARin, MDRin, IRin, Yin,
                 ZLowIn, ZHighIn, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout,
                 Run, Fault, ALU_op};

   typedef struct {
      int          cyc;
      logic [26:0] exp;
      string       name;
   } exp_t;

   typedef struct {
      logic [26:0] exp;
      bit          t1;
      bit          rdy;
      bit          t4;
      bit          bnd;
      string       name;
   } step_t;

   exp_t sb[$];
   exp_t me;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   m_halt = 0;
   bit   m_fault = 0;

   always @(posedge Clock) cyc <= cyc + 1;

   // monitor: every negedge, compare DUT outputs against whatever is due this cycle
   always @(negedge Clock) begin
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
         me = sb.pop_front();
         n_tests++;
         if (me.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s stale entry: due cyc=%0d, now cyc=%0d", me.name, me.cyc, cyc);
         end else if (got !== me.exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", me.name, cyc, got, me.exp);
         end
      end
   end

   function automatic int op_kind(input logic [4:0] op);
      if (op >= 5'd3 && op <= 5'd11) return K_ALU;
      if (op == 5'd14 || op == 5'd15) return K_MULDIV;
      if (op == 5'd26) return K_NOP;
      if (op == 5'd27) return K_HALT;
      return K_ILL;
   endfunction

   function automatic step_t mk(input logic [26:0] e, input bit t1, input bit rdy,
                                input bit t4, input string nm);
      step_t s;
      s.exp = e; s.t1 = t1; s.rdy = rdy; s.t4 = t4; s.bnd = 1'b0; s.name = nm;
      return s;
   endfunction

   task automatic check_zero(input string nm);
      n_tests++;
      if (got !== 27'd0) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h", nm, got, 27'd0);
      end
   endtask

   // Build one instruction's cycle plan from the model, then drive it and queue expectations.
   task automatic run_instr(input logic [31:0] ir, input int d, input bit stop_bnd,
                            input int noise, input bit clr_t4);
      step_t      pl[$];
      exp_t       e;
      int         n1, k;
      logic [4:0] op;
      op = ir[31:27];
      m_halt = 0;
      pl.push_back(mk(W_T0, 0, 0, 0, "T0"));
      n1 = (d >= MEM_TIMEOUT) ? MEM_TIMEOUT : d + 1;
      for (int i = 0; i < n1; i++) pl.push_back(mk(W_T1, 1, (i >= d), 0, "T1"));
      if (d >= MEM_TIMEOUT) begin
         m_halt = 1; m_fault = 1;
      end else begin
         pl.push_back(mk(W_T2, 0, 0, 0, "T2"));
         k = op_kind(op);
         if (k == K_ALU || k == K_MULDIV) begin
            pl.push_back(mk(W_T3, 0, 0, 0, "T3"));
            pl.push_back(mk(W_T4 | {22'd0, op}, 0, 0, 1, "T4"));
            if (k == K_ALU) begin
               pl.push_back(mk(W_T5A, 0, 0, 0, "T5_alu"));
            end else begin
               pl.push_back(mk(W_T5M, 0, 0, 0, "T5_muldiv"));
               pl.push_back(mk(W_T6, 0, 0, 0, "T6"));
            end
         end else if (k == K_HALT) begin
            m_halt = 1;
         end
`ifdef ILLEGAL_OP_TRAP_EN
         else if (k == K_ILL) begin
            m_halt = 1; m_fault = 1;
         end
`endif
         if (!m_halt) begin
            pl[pl.size()-1].bnd = 1'b1;
            if (stop_bnd) m_halt = 1;
         end
      end
      foreach (pl[i]) begin
         @(posedge Clock); #1;
         IR = ir;
         Mem_ready = pl[i].t1 ? pl[i].rdy : 1'($urandom_range(0, 1));
         if (pl[i].bnd) Stop = stop_bnd;
         else if (noise == 2) Stop = 1'b1;
         else if (noise == 1) Stop = 1'($urandom_range(0, 1));
         else Stop = 1'b0;
         if (clr_t4 && pl[i].t4) begin
            #2 Clear = 1'b1;
            #1 check_zero("clear_mid_t4");
            @(negedge Clock);
            Clear = 1'b0;
            m_halt = 0; m_fault = 0;
            return;
         end
         e.cyc = cyc; e.exp = pl[i].exp; e.name = pl[i].name;
         sb.push_back(e);
      end
   endtask

   task automatic halt_and_clear();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clock); #1;
         Stop = 1'($urandom_range(0, 1));
         Mem_ready = 1'($urandom_range(0, 1));
         IR = $urandom;
         e.cyc = cyc; e.exp = m_fault ? M_FAULT : 27'd0; e.name = "HALT";
         sb.push_back(e);
      end
      @(posedge Clock); #2 Clear = 1'b1;
      #1 check_zero("clear_in_halt");
      @(negedge Clock);
      Clear = 1'b0;
      m_halt = 0; m_fault = 0;
   endtask

   task automatic go(input logic [31:0] ir, input int d, input bit stop_bnd,
                     input int noise, input bit clr_t4);
      run_instr(ir, d, stop_bnd, noise, clr_t4);
      if (m_halt) halt_and_clear();
   endtask

   function automatic logic [31:0] mk_ir(input logic [4:0] op);
      return {op, 27'($urandom)};
   endfunction

   logic [4:0] alu_ops [9] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
   logic [4:0] ill_ops [7] = '{5'd0, 5'd1, 5'd2, 5'd12, 5'd13, 5'd16, 5'd31};

   initial begin
      int r, d;
      logic [4:0] op;
      #12 check_zero("reset_state");
      @(negedge Clock);
      Clear = 1'b0;

      go(32'h28918000, 0, 0, 0, 0);
      go(mk_ir(5'b01110), 0, 0, 1, 0);
      go(mk_ir(5'b00101), 3, 0, 1, 0);
      go(mk_ir(5'b00011), 15, 0, 1, 0);
      go(mk_ir(5'b00100), 0, 1, 2, 0);
      go(mk_ir(5'b00110), 0, 0, 2, 0);
      go(mk_ir(5'b00101), 16, 0, 0, 0);
      go(mk_ir(5'b11011), 0, 0, 1, 0);
      go(mk_ir(5'b11111), 0, 0, 1, 0);
      go(mk_ir(5'b11010), 0, 0, 1, 0);
      go(mk_ir(5'b00011), 0, 0, 0, 1);
      go(mk_ir(5'b01111), 1, 1, 1, 0);

      for (int n = 0; n < 80; n++) begin
         r = $urandom_range(0, 19);
         if (r <= 8) op = alu_ops[$urandom_range(0, 8)];
         else if (r <= 11) op = (r[0]) ? 5'b01110 : 5'b01111;
         else if (r <= 13) op = 5'b11010;
         else if (r == 14) op = 5'b11011;
         else if (r <= 16) op = ill_ops[$urandom_range(0, 6)];
         else op = alu_ops[$urandom_range(0, 8)];
         r = $urandom_range(0, 15);
         if (r == 0) d = 16;
         else if (r == 1) d = 15;
         else d = $urandom_range(0, 3);
         go(mk_ir(op), d, ($urandom_range(0, 7) == 0), 1,
            (op_kind(op) == K_ALU && $urandom_range(0, 9) == 0));
      end

      repeat (3) @(posedge Clock);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
